// File: rtl/mem_access.sv
// Load/store stage: registers one memory op, runs the dmem req/ack handshake,
// aligns/extends load data into a register write-back and flags faulting ops.
module mem_access #(
  parameter int cXLEN       = 32,
  parameter int cRegSelBitW = 5,
  parameter int cTimeout    = 255
) (
  input  logic                               iClk,
  input  logic                               iRst,
  // {addr, data, rdAddr, opType[2:0], read, write}
  input  logic [2*cXLEN+cRegSelBitW+4:0]     iMemOp,
  output logic                               oStall,
  output logic                               oDmemReq,
  output logic                               oDmemWe,
  output logic [cXLEN-1:0]                   oDmemAddr,
  output logic [3:0]                         oDmemBe,
  output logic [cXLEN-1:0]                   oDmemWData,
  input  logic                               iDmemAck,
  input  logic [cXLEN-1:0]                   iDmemRData,
  // {addr, data, dv}
  output logic [cRegSelBitW+cXLEN:0]         oRegWB,
  output logic                               oExcValid,
  output logic [1:0]                         oExcCause,
  output logic [cXLEN-1:0]                   oExcAddr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;
  localparam logic [7:0] TO_LAST = 8'(cTimeout - 1);

  logic                   op_write, op_read;
  logic [2:0]             op_type;
  logic [cRegSelBitW-1:0] op_rd;
  logic [cXLEN-1:0]       op_data, op_addr;

  assign op_write = iMemOp[0];
  assign op_read  = iMemOp[1];
  assign op_type  = iMemOp[4:2];
  assign op_rd    = iMemOp[cRegSelBitW+4:5];
  assign op_data  = iMemOp[cXLEN+cRegSelBitW+4:cRegSelBitW+5];
  assign op_addr  = iMemOp[2*cXLEN+cRegSelBitW+4:cXLEN+cRegSelBitW+5];

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [cXLEN-1:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [cRegSelBitW-1:0] rd_q, rd_d, wb_addr_q, wb_addr_d;
  logic [2:0]             type_q, type_d;
  logic                   we_q, we_d;
  logic [3:0]             be_q, be_d;
  logic [cXLEN-1:0]       wb_data_q, wb_data_d;
  logic                   wb_dv_q, wb_dv_d;
  logic                   exc_valid_q, exc_valid_d;
  logic [1:0]             exc_cause_q, exc_cause_d;
  logic [cXLEN-1:0]       exc_addr_q, exc_addr_d;

  logic                   op_illegal, op_misal;
  logic [3:0]             st_be;
  logic [cXLEN-1:0]       st_wdata, ld_sh, ld_ext;

  assign op_illegal = (op_read & op_write)
                    | (op_read & (op_type == 3'b011 || op_type == 3'b110 || op_type == 3'b111))
                    | (op_write & (op_type[2] | (op_type[1:0] == 2'b11)));
  assign op_misal   = ((op_type[1:0] == 2'b01) & op_addr[0])
                    | ((op_type[1:0] == 2'b10) & (op_addr[1:0] != 2'b00));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = op_data;
    case (op_type[1:0])
      2'b00: begin st_be = 4'b0001 << op_addr[1:0]; st_wdata = {4{op_data[7:0]}};  end
      2'b01: begin st_be = 4'b0011 << op_addr[1:0]; st_wdata = {2{op_data[15:0]}}; end
      default: ;
    endcase
  end

  // Extraction works straight off the ack-cycle read word, so WB needs no extra stage.
  assign ld_sh = iDmemRData >> {addr_q[1:0], 3'b000};
  always_comb begin
    ld_ext = iDmemRData;
    case (type_q)
      3'b000: ld_ext = {{(cXLEN-8){ld_sh[7]}},   ld_sh[7:0]};
      3'b001: ld_ext = {{(cXLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b100: ld_ext = {{(cXLEN-8){1'b0}},       ld_sh[7:0]};
      3'b101: ld_ext = {{(cXLEN-16){1'b0}},      ld_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    type_d      = type_q;
    we_d        = we_q;
    be_d        = be_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_dv_d     = 1'b0;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      S_IDLE: if (op_read | op_write) begin
        if (op_illegal || op_misal) begin
          exc_valid_d = 1'b1;
          exc_cause_d = op_illegal ? 2'b10 : 2'b01;
          exc_addr_d  = op_addr;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
          addr_d  = op_addr;
          rd_d    = op_rd;
          type_d  = op_type;
          we_d    = op_write;
          be_d    = st_be;
          wdata_d = st_wdata;
        end
      end
      S_WAIT: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (iDmemAck) begin
          if (we_q) state_d = S_IDLE;
          else begin
            state_d   = S_WB;
            wb_dv_d   = (rd_q != '0);
            wb_addr_d = rd_q;
            wb_data_d = ld_ext;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_IDLE;
          exc_valid_d = 1'b1;
          exc_cause_d = 2'b11;
          exc_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      type_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_dv_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      type_q      <= type_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_dv_q     <= wb_dv_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign oStall     = (state_q != S_IDLE);
  assign oDmemReq   = (state_q == S_WAIT);
  assign oDmemWe    = we_q;
  assign oDmemAddr  = {addr_q[cXLEN-1:2], 2'b00};
  assign oDmemBe    = be_q;
  assign oDmemWData = wdata_q;
  assign oRegWB     = {wb_addr_q, wb_data_q, wb_dv_q};
  assign oExcValid  = exc_valid_q;
  assign oExcCause  = exc_cause_q;
  assign oExcAddr   = exc_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboarded bench for mem_access: directed ops push expected req/wb/exc
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_mem_access;
  logic        iClk = 1'b0, iRst = 1'b1;
  logic [73:0] iMemOp = '0;
  logic        oStall, oDmemReq, oDmemWe, iDmemAck = 1'b0;
  logic [31:0] oDmemAddr, oDmemWData, iDmemRData = '0, oExcAddr;
  logic [3:0]  oDmemBe;
  logic [37:0] oRegWB;
  logic        oExcValid;
  logic [1:0]  oExcCause;

  mem_access #(.cXLEN(32), .cRegSelBitW(5), .cTimeout(4)) dut (
    .iClk(iClk), .iRst(iRst), .iMemOp(iMemOp), .oStall(oStall),
    .oDmemReq(oDmemReq), .oDmemWe(oDmemWe), .oDmemAddr(oDmemAddr),
    .oDmemBe(oDmemBe), .oDmemWData(oDmemWData), .iDmemAck(iDmemAck),
    .iDmemRData(iDmemRData), .oRegWB(oRegWB), .oExcValid(oExcValid),
    .oExcCause(oExcCause), .oExcAddr(oExcAddr));

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
  req_t        req_sb[$];
  logic [36:0] wb_sb[$];
  logic [33:0] exc_sb[$];
  int n_chk = 0, n_fail = 0, stall_cnt = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (oStall) stall_cnt++;
    if (oDmemReq && !req_prev) begin
      if (req_sb.size() == 0) chk("unexpected_req", {32'h0, oDmemAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        req_t e;
        e = req_sb.pop_front();
        chk("req_addr", oDmemAddr, e.addr);
        chk("req_we", oDmemWe, e.we);
        if (e.we) begin
          chk("req_be", oDmemBe, e.be);
          chk("req_wdata", oDmemWData, e.wdata);
        end
      end
    end
    req_prev <= oDmemReq;
    if (oRegWB[0]) begin
      if (wb_sb.size() == 0) chk("unexpected_wb", oRegWB[37:1], 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("wb", oRegWB[37:1], wb_sb.pop_front());
    end
    if (oExcValid) begin
      if (exc_sb.size() == 0) chk("unexpected_exc", {oExcCause, oExcAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("exc", {oExcCause, oExcAddr}, exc_sb.pop_front());
    end
  end

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd;
    req_sb.push_back(r);
  endtask

  // Called at #1 after an edge with the DUT idle; drives the op for one cycle.
  // ack_dly < 0 means no ack: wait out exp_stall cycles (0 for exceptions).
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rda,
                       input logic [2:0] t, input logic rdn, input logic wrn,
                       input int ack_dly, input logic [31:0] rdata, input int exp_stall);
    stall_cnt = 0;
    iMemOp = {a, d, rda, t, rdn, wrn};
    @(posedge iClk) #1;
    iMemOp = '0;
    if (ack_dly >= 0) begin
      repeat (ack_dly) @(posedge iClk) #1;
      iDmemAck = 1'b1; iDmemRData = rdata;
      @(posedge iClk) #1;
      iDmemAck = 1'b0;
      if (rdn) begin
        chk("wb_latency_dv", oRegWB[0], rda != 5'd0);
        @(posedge iClk) #1;
      end
    end else begin
      repeat (exp_stall) @(posedge iClk) #1;
    end
    chk("stall_cycles", stall_cnt, exp_stall);
  endtask

  initial begin
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_stall", oStall, 0);
    chk("rst_req", oDmemReq, 0);
    chk("rst_we", oDmemWe, 0);
    chk("rst_addr", oDmemAddr, 0);
    chk("rst_be", oDmemBe, 0);
    chk("rst_wb", oRegWB, 0);
    chk("rst_exc", {oExcValid, oExcCause, oExcAddr}, 0);
    iRst = 1'b0;
    @(posedge iClk) #1;

    // Loads: byte/half sign and zero extension by offset
    push_req(32'h100, 0, 0, 0); wb_sb.push_back({5'd5, 32'hFFFF_FF80});
    do_op(32'h103, 0, 5'd5, 3'b000, 1, 0, 0, 32'h80FF_1234, 2);
    push_req(32'h100, 0, 0, 0); wb_sb.push_back({5'd6, 32'h0000_0080});
    do_op(32'h103, 0, 5'd6, 3'b100, 1, 0, 0, 32'h80FF_1234, 2);
    push_req(32'h100, 0, 0, 0); wb_sb.push_back({5'd7, 32'hFFFF_80FF});
    do_op(32'h102, 0, 5'd7, 3'b001, 1, 0, 0, 32'h80FF_1234, 2);
    push_req(32'h100, 0, 0, 0); wb_sb.push_back({5'd10, 32'h0000_1234});
    do_op(32'h100, 0, 5'd10, 3'b101, 1, 0, 0, 32'h80FF_1234, 2);

    // Stores; SB is followed by a back-to-back accept
    push_req(32'h200, 1, 4'b1100, 32'hABCD_ABCD);
    do_op(32'h202, 32'h0000_ABCD, 5'd0, 3'b001, 0, 1, 3, 0, 4);
    push_req(32'h700, 1, 4'b0010, 32'hA5A5_A5A5);
    do_op(32'h701, 32'h0000_00A5, 5'd0, 3'b000, 0, 1, 0, 0, 1);

    // Exceptions: misaligned and illegal
    exc_sb.push_back({2'b01, 32'h101});
    do_op(32'h101, 0, 5'd3, 3'b010, 1, 0, -1, 0, 0);
    exc_sb.push_back({2'b10, 32'h300});
    do_op(32'h300, 0, 5'd3, 3'b011, 1, 0, -1, 0, 0);
    exc_sb.push_back({2'b10, 32'h304});
    do_op(32'h304, 0, 5'd0, 3'b100, 0, 1, -1, 0, 0);
    exc_sb.push_back({2'b10, 32'h308});
    do_op(32'h308, 0, 5'd3, 3'b010, 1, 1, -1, 0, 0);
    exc_sb.push_back({2'b01, 32'h306});
    do_op(32'h306, 32'h1, 5'd0, 3'b010, 0, 1, -1, 0, 0);

    // Timeout, then ack landing exactly on the timeout cycle
    push_req(32'h400, 0, 0, 0); exc_sb.push_back({2'b11, 32'h400});
    do_op(32'h400, 0, 5'd7, 3'b010, 1, 0, -1, 0, 4);
    chk("post_timeout_req", oDmemReq, 0);
    push_req(32'h800, 0, 0, 0); wb_sb.push_back({5'd9, 32'h1122_3344});
    do_op(32'h800, 0, 5'd9, 3'b010, 1, 0, 3, 32'h1122_3344, 5);

    // Reset mid-WAIT, then a stray ack
    push_req(32'h500, 0, 0, 0);
    iMemOp = {32'h500, 32'h0, 5'd8, 3'b010, 1'b1, 1'b0};
    @(posedge iClk) #1;
    iMemOp = '0;
    @(posedge iClk) #1;
    chk("pre_rst_req", oDmemReq, 1);
    iRst = 1'b1;
    #1;
    chk("async_rst_req", oDmemReq, 0);
    chk("async_rst_stall", oStall, 0);
    @(posedge iClk) #1;
    iRst = 1'b0; iDmemAck = 1'b1; iDmemRData = 32'hCAFE_F00D;
    @(posedge iClk) #1;
    iDmemAck = 1'b0;
    chk("stray_ack_dv", oRegWB[0], 0);
    chk("stray_ack_stall", oStall, 0);
    @(posedge iClk) #1;

    // Load to x0 then a clean SW
    push_req(32'h600, 0, 0, 0);
    do_op(32'h600, 0, 5'd0, 3'b010, 1, 0, 1, 32'hDEAD_BEEF, 3);
    push_req(32'h604, 1, 4'b1111, 32'h1234_5678);
    do_op(32'h604, 32'h1234_5678, 5'd0, 3'b010, 0, 1, 0, 0, 1);

    repeat (3) @(posedge iClk);
    #1;
    chk("req_sb_drained", req_sb.size(), 0);
    chk("wb_sb_drained", wb_sb.size(), 0);
    chk("exc_sb_drained", exc_sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
